// File: rtl/cb_pkg.sv
// Shared helpers for the parametrised connection block: widths of the
// per-pin configuration fields and the value driven by an unused select.
package cb_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int sel_width(input int fc);
    return clog2(2 * fc);
  endfunction

  function automatic int pin_bits(input int fc);
    return sel_width(fc) + 1;
  endfunction

  function automatic int cfg_bits(input int num_ipin, input int fc);
    return num_ipin * pin_bits(fc);
  endfunction

  // Pin value when the select code points past the last mux input.
  localparam logic SEL_OOR_VALUE = 1'b0;

endpackage

// File: rtl/cb_cfg_chain.sv
// Counted, shadowed configuration scan chain: bits shift into sh_reg and are
// copied to the active register only by a commit after exactly CFG_BITS shifts.
module cb_cfg_chain
  import cb_pkg::*;
#(
  parameter int CFG_BITS = 21
) (
  input  logic                prog_clk,
  input  logic                prog_rst_n,
  input  logic                ccff_head,
  input  logic                ccff_en,
  input  logic                ccff_commit,
  output logic [CFG_BITS-1:0] act,
  output logic                ccff_tail,
  output logic                cfg_valid,
  output logic                cfg_err
);

  localparam int CNT_W = clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  logic [CFG_BITS-1:0] sh_reg;
  logic [CFG_BITS-1:0] act_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                valid_reg;
  logic                err_reg;

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      sh_reg    <= '0;
      act_reg   <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else if (ccff_commit) begin
      // Commit wins over shift; a simultaneous shift request is itself an error.
      cnt_reg <= '0;
      if (cnt_reg == CNT_FULL) begin
        act_reg   <= sh_reg;
        valid_reg <= 1'b1;
      end
      if (ccff_en || (cnt_reg != CNT_FULL)) err_reg <= 1'b1;
    end else if (ccff_en) begin
      sh_reg <= {sh_reg[CFG_BITS-2:0], ccff_head};
      if (cnt_reg != CNT_SAT) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign act       = act_reg;
  assign ccff_tail = sh_reg[CFG_BITS-1];
  assign cfg_valid = valid_reg;
  assign cfg_err   = err_reg;

endmodule

// File: rtl/cbx_param_cfg.sv
// X-channel connection block: track passthroughs plus one configurable
// 2*FC-input mux per grid input pin, configured through cb_cfg_chain.
module cbx_param_cfg
  import cb_pkg::*;
#(
  parameter int CHAN_W   = 4,
  parameter int NUM_IPIN = 7,
  parameter int FC       = 2
) (
  input  logic                prog_clk,
  input  logic                prog_rst_n,
  input  logic [CHAN_W-1:0]   chanx_left_in,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  output logic [CHAN_W-1:0]   chanx_left_out,
  output logic [CHAN_W-1:0]   chanx_right_out,
  input  logic                ccff_head,
  input  logic                ccff_en,
  input  logic                ccff_commit,
  output logic                ccff_tail,
  output logic [NUM_IPIN-1:0] ipin_out,
  output logic                cfg_valid,
  output logic                cfg_err
);

  localparam int SEL_W    = sel_width(FC);
  localparam int B        = pin_bits(FC);
  localparam int CFG_BITS = cfg_bits(NUM_IPIN, FC);

  logic [CFG_BITS-1:0] act;

  assign chanx_left_out  = chanx_right_in;
  assign chanx_right_out = chanx_left_in;

  cb_cfg_chain #(
    .CFG_BITS(CFG_BITS)
  ) u_chain (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .ccff_head  (ccff_head),
    .ccff_en    (ccff_en),
    .ccff_commit(ccff_commit),
    .act        (act),
    .ccff_tail  (ccff_tail),
    .cfg_valid  (cfg_valid),
    .cfg_err    (cfg_err)
  );

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_IPIN; gi++) begin : g_pin
      logic [2*FC-1:0] mux_in;
      logic [SEL_W-1:0] pin_sel;
      logic             pin_en;
      logic             pin_val;

      // Even codes pick the left track, odd codes the right, rotated by pin index.
      for (gj = 0; gj < FC; gj++) begin : g_tap
        assign mux_in[2*gj]   = chanx_left_in[(gi + gj) % CHAN_W];
        assign mux_in[2*gj+1] = chanx_right_in[(gi + gj) % CHAN_W];
      end

      assign pin_sel = act[gi*B +: SEL_W];
      assign pin_en  = act[gi*B + B - 1];

      always_comb begin
        pin_val = SEL_OOR_VALUE;
        if (int'(pin_sel) < 2 * FC) pin_val = mux_in[pin_sel];
        if (!pin_en) pin_val = 1'b0;
      end

      assign ipin_out[gi] = pin_val;
    end
  endgenerate

endmodule

// File: tb/tb_cbx_param_cfg.sv
// Directed bench for cbx_param_cfg: default FC=2 instance plus an FC=3
// instance for the wide-select and out-of-range select cases.
module tb_cbx_param_cfg;

  logic       prog_clk;
  logic       prog_rst_n;
  logic [3:0] chanx_left_in;
  logic [3:0] chanx_right_in;
  logic [1:0] head;
  logic [1:0] en;
  logic [1:0] commit;

  logic [3:0] left_out_a, right_out_a, left_out_b, right_out_b;
  logic       tail_a, tail_b, valid_a, valid_b, err_a, err_b;
  logic [6:0] ipin_a, ipin_b;

  int n_checks;
  int n_fail;

  cbx_param_cfg #(.CHAN_W(4), .NUM_IPIN(7), .FC(2)) dut_a (
    .prog_clk       (prog_clk),
    .prog_rst_n     (prog_rst_n),
    .chanx_left_in  (chanx_left_in),
    .chanx_right_in (chanx_right_in),
    .chanx_left_out (left_out_a),
    .chanx_right_out(right_out_a),
    .ccff_head      (head[0]),
    .ccff_en        (en[0]),
    .ccff_commit    (commit[0]),
    .ccff_tail      (tail_a),
    .ipin_out       (ipin_a),
    .cfg_valid      (valid_a),
    .cfg_err        (err_a)
  );

  cbx_param_cfg #(.CHAN_W(4), .NUM_IPIN(7), .FC(3)) dut_b (
    .prog_clk       (prog_clk),
    .prog_rst_n     (prog_rst_n),
    .chanx_left_in  (chanx_left_in),
    .chanx_right_in (chanx_right_in),
    .chanx_left_out (left_out_b),
    .chanx_right_out(right_out_b),
    .ccff_head      (head[1]),
    .ccff_en        (en[1]),
    .ccff_commit    (commit[1]),
    .ccff_tail      (tail_b),
    .ipin_out       (ipin_b),
    .cfg_valid      (valid_b),
    .cfg_err        (err_b)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // Sends d[n-1] first, so after n shifts sh == d[n-1:0].
  task automatic shift_bits(input int w, input int n, input logic [63:0] d);
    for (int i = n - 1; i >= 0; i--) begin
      head[w] = d[i];
      en[w]   = 1'b1;
      tick();
    end
    en[w]   = 1'b0;
    head[w] = 1'b0;
  endtask

  task automatic do_commit(input int w);
    commit[w] = 1'b1;
    tick();
    commit[w] = 1'b0;
  endtask

  task automatic do_reset();
    prog_rst_n = 1'b0;
    tick();
    tick();
    prog_rst_n = 1'b1;
    tick();
  endtask

  logic [63:0] s_stream;

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    prog_rst_n     = 1'b0;
    chanx_left_in  = 4'h0;
    chanx_right_in = 4'h0;
    head           = 2'b00;
    en             = 2'b00;
    commit         = 2'b00;

    // 1: reset state and passthroughs
    do_reset();
    check("rst_ipin", ipin_a, 7'h00);
    check("rst_valid", valid_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    check("rst_tail", tail_a, 1'b0);
    check("rst_ipin_b", ipin_b, 7'h00);
    chanx_left_in = 4'hF;
    #1;
    check("pass_right_out", right_out_a, 4'hF);
    check("rst_ipin_chan", ipin_a, 7'h00);
    chanx_right_in = 4'h9;
    #1;
    check("pass_left_out", left_out_a, 4'h9);
    chanx_left_in  = 4'h0;
    chanx_right_in = 4'h0;

    // 2: pin0 enable, sel 3 -> chanx_right_in[1]
    shift_bits(0, 21, 64'h7);
    check("pre_commit_valid", valid_a, 1'b0);
    do_commit(0);
    check("good_valid", valid_a, 1'b1);
    check("good_err", err_a, 1'b0);
    chanx_right_in = 4'b0010;
    #1;
    check("pin0_hi", ipin_a, 7'h01);
    chanx_right_in = 4'b1101;
    #1;
    check("pin0_lo", ipin_a, 7'h00);
    chanx_right_in = 4'hF;
    chanx_left_in  = 4'hF;
    #1;
    check("pin0_only", ipin_a, 7'h01);

    // 3: short shift -> error, config held; then a full load applies
    shift_bits(0, 20, 64'h0);
    do_commit(0);
    check("short_err", err_a, 1'b1);
    check("short_valid", valid_a, 1'b1);
    check("short_ipin", ipin_a, 7'h01);
    // pin6 sel2 -> left[3], pin4 disabled sel1, pin2 sel0 -> left[2]
    shift_bits(0, 21, 64'h181100);
    do_commit(0);
    check("reload_err_sticky", err_a, 1'b1);
    check("reload_valid", valid_a, 1'b1);
    chanx_left_in  = 4'b0100;
    chanx_right_in = 4'b0000;
    #1;
    check("reload_pin2", ipin_a, 7'b0000100);
    chanx_left_in = 4'b1000;
    #1;
    check("reload_pin6", ipin_a, 7'b1000000);
    chanx_left_in  = 4'b0000;
    chanx_right_in = 4'hF;
    #1;
    check("reload_pin4_disabled", ipin_a, 7'h00);

    // 4: FC=3 instance, wrap and out-of-range selects
    shift_bits(1, 28, 64'hD00C);
    do_commit(1);
    check("b_valid", valid_b, 1'b1);
    check("b_err", err_b, 1'b0);
    chanx_left_in  = 4'b0100;
    chanx_right_in = 4'b0000;
    #1;
    check("b_pin0_sel4", ipin_b, 7'b0000001);
    chanx_left_in  = 4'b0000;
    chanx_right_in = 4'b0010;
    #1;
    check("b_pin3_sel5_wrap", ipin_b, 7'b0001000);
    chanx_right_in = 4'b1101;
    #1;
    check("b_pin3_sel5_lo", ipin_b, 7'b0000000);
    shift_bits(1, 28, 64'hE000);
    do_commit(1);
    chanx_left_in  = 4'hF;
    chanx_right_in = 4'hF;
    #1;
    check("b_pin3_sel6", ipin_b, 7'h00);
    shift_bits(1, 28, 64'hF000);
    do_commit(1);
    #1;
    check("b_pin3_sel7", ipin_b, 7'h00);
    check("b_err_after", err_b, 1'b0);

    // 5: readback of the committed stream, then simultaneous shift+commit
    s_stream = 64'h181100;
    for (int k = 20; k >= 0; k--) begin
      check($sformatf("readback_%0d", k), tail_a, s_stream[k]);
      shift_bits(0, 1, 64'h0);
    end
    check("readback_flushed", tail_a, 1'b0);

    do_reset();
    shift_bits(0, 21, 64'h155555);
    check("both_pre_err", err_a, 1'b0);
    check("both_pre_tail", tail_a, 1'b1);
    head[0]   = 1'b0;
    en[0]     = 1'b1;
    commit[0] = 1'b1;
    tick();
    en[0]     = 1'b0;
    commit[0] = 1'b0;
    check("both_err", err_a, 1'b1);
    check("both_no_shift", tail_a, 1'b1);
    shift_bits(0, 1, 64'h0);
    check("both_next_bit", tail_a, 1'b0);

    // 6: asynchronous reset mid-shift with a live config
    do_reset();
    shift_bits(0, 21, 64'h7);
    do_commit(0);
    chanx_right_in = 4'b0010;
    #1;
    check("async_pre_ipin", ipin_a, 7'h01);
    check("async_pre_valid", valid_a, 1'b1);
    shift_bits(0, 10, 64'h3FF);
    head[0] = 1'b1;
    en[0]   = 1'b1;
    #2;
    prog_rst_n = 1'b0;
    #1;
    check("async_ipin", ipin_a, 7'h00);
    check("async_valid", valid_a, 1'b0);
    check("async_tail", tail_a, 1'b0);
    en[0]   = 1'b0;
    head[0] = 1'b0;
    tick();
    prog_rst_n = 1'b1;
    tick();
    // Counter was cleared: an 11-bit remainder must not commit.
    shift_bits(0, 11, 64'h7);
    do_commit(0);
    check("async_partial_err", err_a, 1'b1);
    check("async_partial_valid", valid_a, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
